// File: rtl/myproject_acc_bias_relu.sv
// Streaming accumulate-bias-activate stage.
// Sums N_IN signed products onto a per-group bias, then rounds half up,
// applies optional ReLU and saturates to the OUT_WIDTH activation format.
// Ports:
//   ap_clk, ap_rst_n        clock, async active-low reset
//   in_data, bias           signed product / bias (bias sampled on first beat)
//   in_valid, in_ready      upstream handshake
//   out_data, out_sat       activation and its saturation flag
//   out_valid, out_ready    downstream handshake
module myproject_acc_bias_relu #(
  parameter int unsigned N_IN       = 72,
  parameter int unsigned PROD_WIDTH = 25,
  parameter int unsigned ACC_WIDTH  = 33,
  parameter int unsigned SHIFT      = 9,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned RELU       = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic signed [PROD_WIDTH-1:0] bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned CNT_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned RND_W    = ACC_WIDTH + 1;
  localparam int unsigned HALF_POS = (SHIFT == 0) ? 0 : SHIFT - 1;
  localparam logic signed [RND_W-1:0] HALF =
    (SHIFT == 0) ? RND_W'(0) : (RND_W'(1) << HALF_POS);
  localparam logic signed [RND_W-1:0] OUT_MAX =
    RND_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RND_W-1:0] OUT_MIN =
    RND_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {ACC, SCALE, OUT} state_t;

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [OUT_WIDTH-1:0]  data_q, data_d;
  logic                         sat_q, sat_d;
  logic                         valid_q, valid_d;
  logic                         ready_q, ready_d;

  logic                         accept_c;
  logic signed [ACC_WIDTH-1:0]  base_c;
  logic signed [RND_W-1:0]      rnd_c, shr_c, relu_c;
  logic signed [OUT_WIDTH-1:0]  clamp_c;
  logic                         clamp_hit_c;

  // Round half up, ReLU, saturate; widened by one bit so the round add never wraps.
  always_comb begin
    rnd_c       = RND_W'(acc_q) + HALF;
    shr_c       = rnd_c >>> SHIFT;
    relu_c      = ((RELU != 0) && shr_c[RND_W-1]) ? RND_W'(0) : shr_c;
    clamp_hit_c = 1'b0;
    clamp_c     = relu_c[OUT_WIDTH-1:0];
    if (relu_c > OUT_MAX) begin
      clamp_c     = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      clamp_hit_c = 1'b1;
    end else if (relu_c < OUT_MIN) begin
      clamp_c     = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      clamp_hit_c = 1'b1;
    end
  end

  // Bias replaces the running sum on the first beat of a group.
  always_comb begin
    accept_c = in_valid && ready_q;
    base_c   = (cnt_q == '0) ? ACC_WIDTH'(bias) : acc_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    case (state_q)
      ACC: begin
        if (accept_c) begin
          acc_d = base_c + ACC_WIDTH'(in_data);
          if (cnt_q == CNT_W'(N_IN - 1)) begin
            cnt_d   = '0;
            state_d = SCALE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SCALE: begin
        data_d  = clamp_c;
        sat_d   = clamp_hit_c;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    ready_d = (state_d == ACC);
  end

  // State and output registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = data_q;
  assign out_sat   = sat_q;
  assign out_valid = valid_q;

endmodule
